// File: rtl/seq_calc_pkg.sv
// Shared definitions for the sequential calculator: opcodes, FSM encoding and
// the elaboration-time sizing helper for the BCD output.
package seq_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  // Decimal digits needed to show the largest bin_w-bit unsigned value.
  function automatic int digits_required(input int bin_w);
    longint unsigned v;
    int              d;
    v = (64'd1 << bin_w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/seq_calculator_if.sv
// Start/busy/done request interface between a requester and seq_calculator.
interface seq_calculator_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [2:0]            op;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;
  logic                  err;

  modport master (
    output start, a, b, op,
    input  busy, done, bcd_out, neg, err
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, bcd_out, neg, err
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, BIN_W steps total.
// done is high during the final step; bcd carries that step's result.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_shift;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic [3:0]       nib;

  // Each nibble is corrected, then its top bit carries into the next nibble.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bcd_shift    = '0;
    nib          = '0;
    bcd_shift[0] = bin_sr[BIN_W-1];
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd_sr[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_shift[4*i+1 +: 3] = nib[2:0];
      if (i < DIGITS - 1) bcd_shift[4*i+4] = nib[3];
    end
  end

  assign done = active && (cnt == CNT_W'(BIN_W - 1));
  assign bcd  = bcd_shift;

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      bin_sr <= bin;
      bcd_sr <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
      bcd_sr <= bcd_shift;
      cnt    <= cnt + CNT_W'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle calculator: iterative multiply/divide in EXEC, sequential
// binary-to-BCD in CONV, registered BCD/sign/error results for the display path.
module seq_calculator
  import seq_calc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  seq_calculator_if.slave  bus
);

  localparam int RES_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("seq_calculator: WIDTH must lie in 2..16");
  end
  if (DIGITS < digits_required(RES_W)) begin : g_digits_check
    $error("seq_calculator: DIGITS too small for a 2*WIDTH-bit result");
  end

  state_t              state, state_n;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [2:0]          op_q;
  logic [RES_W-1:0]    acc, acc_step, result;
  logic [CNT_W-1:0]    step_cnt;
  logic                neg_pend;
  logic                div_op, iterative, div_zero, exec_last;
  logic [WIDTH:0]      mul_sum, div_rem, div_diff;
  logic                conv_load, conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                busy_q, done_q, neg_q, err_q;
  logic [4*DIGITS-1:0] bcd_q;

  assign div_op    = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign iterative = div_op || (op_q == OP_MUL);
  assign div_zero  = div_op && (b_q == '0);
  assign exec_last = !iterative || (step_cnt == CNT_W'(WIDTH - 1));

  // acc is {hi, lo}: multiply keeps {partial product, remaining multiplier},
  // divide keeps {partial remainder, dividend bits turning into quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[RES_W-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    div_rem  = {acc[RES_W-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_rem - {1'b0, b_q};
    acc_step = acc;
    if (op_q == OP_MUL)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_op)
      acc_step = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    case (op_q)
      OP_ADD:  result = RES_W'(a_q) + RES_W'(b_q);
      OP_SUB:  result = (a_q >= b_q) ? RES_W'(a_q - b_q) : RES_W'(b_q - a_q);
      OP_MUL:  result = acc_step;
      OP_DIV:  result = RES_W'(acc_step[WIDTH-1:0]);
      OP_MOD:  result = RES_W'(acc_step[RES_W-1:WIDTH]);
      OP_AND:  result = RES_W'(a_q & b_q);
      OP_OR:   result = RES_W'(a_q | b_q);
      OP_XOR:  result = RES_W'(a_q ^ b_q);
      default: result = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    conv_load = 1'b0;
    case (state)
      IDLE: if (bus.start) state_n = EXEC;
      EXEC: begin
        if (div_zero) begin
          state_n = DONE;
        end else if (exec_last) begin
          state_n   = CONV;
          conv_load = 1'b1;
        end
      end
      CONV:    if (conv_done) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == EXEC) || (state_n == CONV);
      done_q <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      acc      <= '0;
      step_cnt <= '0;
      neg_pend <= 1'b0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= bus.op;
            acc      <= {{WIDTH{1'b0}}, (bus.op == OP_MUL) ? bus.b : bus.a};
            step_cnt <= '0;
          end
        end
        EXEC: begin
          acc      <= acc_step;
          step_cnt <= step_cnt + CNT_W'(1);
          neg_pend <= (op_q == OP_SUB) && (a_q < b_q);
          if (div_zero) begin
            bcd_q <= '0;
            neg_q <= 1'b0;
            err_q <= 1'b1;
          end
        end
        CONV: begin
          if (conv_done) begin
            bcd_q <= conv_bcd;
            neg_q <= neg_pend;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq #(
    .BIN_W  (RES_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .load  (conv_load),
    .bin   (result),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.neg     = neg_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Scoreboard bench for seq_calculator at WIDTH=4/DIGITS=4 and WIDTH=8/DIGITS=5.
module tb_seq_calculator;
  import seq_calc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_calculator_if #(.WIDTH(4), .DIGITS(4)) bus4 ();
  seq_calculator_if #(.WIDTH(8), .DIGITS(5)) bus8 ();

  seq_calculator #(.WIDTH(4), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  seq_calculator #(.WIDTH(8), .DIGITS(5)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct packed {
    logic [23:0] bcd;
    logic        neg;
    logic        err;
    logic [31:0] edge_no;
  } exp_t;

  exp_t        q4[$];
  exp_t        q8[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] last4    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic, then decimal digits by repeated division.
  function automatic exp_t model(input int w, input logic [2:0] op, input int a,
                                 input int b, input int e0);
    exp_t   e;
    longint r;
    int     lat;
    e = '0;
    r = 0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: begin r = (a >= b) ? a - b : b - a; e.neg = (a < b); end
      OP_MUL: r = longint'(a) * longint'(b);
      OP_DIV: if (b == 0) e.err = 1'b1; else r = a / b;
      OP_MOD: if (b == 0) e.err = 1'b1; else r = a % b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = a ^ b;
    endcase
    lat = e.err ? 1 : (op inside {OP_MUL, OP_DIV, OP_MOD}) ? 3 * w : 1 + 2 * w;
    for (int i = 0; i < 6; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.edge_no = 32'(e0 + lat);
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [23:0] bcd,
                         input logic neg, input logic err);
    check({tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
    check({tag, "_neg"}, 32'(neg), 32'(e.neg));
    check({tag, "_err"}, 32'(err), 32'(e.err));
    check({tag, "_latency_edge"}, 32'(cyc), e.edge_no);
  endtask

  always @(negedge clk) begin
    if (!reset && bus4.done) begin
      check("w4_done_pending", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) compare("w4", q4.pop_front(), {8'h0, bus4.bcd_out}, bus4.neg, bus4.err);
    end
  end

  always @(negedge clk) begin
    if (!reset && bus8.done) begin
      check("w8_done_pending", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) compare("w8", q8.pop_front(), {4'h0, bus8.bcd_out}, bus8.neg, bus8.err);
    end
  end

  // One W4 operation; junk adds start pulses during busy and during DONE.
  task automatic run4(input logic [2:0] op, input int a, input int b, input bit junk);
    exp_t e;
    int   lat;
    int   busy_n = 0;
    int   done_n = 0;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.op    = op;
    bus4.a     = 4'(a);
    bus4.b     = 4'(b);
    e   = model(4, op, a, b, cyc + 1);
    lat = int'(e.edge_no) - (cyc + 1);
    q4.push_back(e);
    @(negedge clk);
    for (int k = 0; k < lat + 4; k++) begin
      if (k == 0) begin
        bus4.start = 1'b0;
        bus4.a     = 4'($urandom);
        bus4.b     = 4'($urandom);
        bus4.op    = 3'($urandom);
        check("w4_hold_bcd_while_busy", 32'(bus4.bcd_out), 32'(last4));
      end
      if (junk && lat > 3 && k == 1) bus4.start = 1'b1;
      if (junk && lat > 3 && k == 2) bus4.start = 1'b0;
      if (junk && k == lat) bus4.start = bus4.done;
      if (junk && k == lat + 1) bus4.start = 1'b0;
      if (bus4.busy) busy_n++;
      if (bus4.done) done_n++;
      @(negedge clk);
    end
    check("w4_busy_cycles", 32'(busy_n), 32'(lat));
    check("w4_done_pulses", 32'(done_n), 32'd1);
    check("w4_sb_drained", 32'(q4.size()), 32'd0);
    q4.delete();
    last4 = e.bcd[15:0];
  endtask

  task automatic run8(input logic [2:0] op, input int a, input int b);
    exp_t e;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = 8'(a);
    bus8.b     = 8'(b);
    e = model(8, op, a, b, cyc + 1);
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int k = 0; k < 40 && q8.size() > 0; k++) @(negedge clk);
    check("w8_sb_drained", 32'(q8.size()), 32'd0);
    q8.delete();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_n;
    reset      = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.op = OP_ADD;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = OP_ADD;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus4.busy), 32'd0);
    check("reset_done", 32'(bus4.done), 32'd0);
    check("reset_bcd", 32'(bus4.bcd_out), 32'd0);
    check("reset_neg", 32'(bus4.neg), 32'd0);
    check("reset_err", 32'(bus4.err), 32'd0);
    check("reset_w8_bcd", 32'(bus8.bcd_out), 32'd0);
    reset = 1'b0;

    run4(OP_ADD, 9, 7, 1);
    run4(OP_SUB, 3, 12, 0);
    run4(OP_SUB, 12, 3, 1);
    run4(OP_MUL, 15, 15, 1);
    run4(OP_DIV, 13, 4, 0);
    run4(OP_MOD, 13, 4, 0);
    run4(OP_DIV, 7, 0, 1);
    run4(OP_ADD, 1, 1, 0);
    run4(OP_MOD, 9, 0, 0);
    run4(OP_AND, 12, 10, 0);
    run4(OP_OR, 12, 10, 0);
    run4(OP_XOR, 12, 10, 1);
    run4(OP_ADD, 15, 15, 0);
    run4(OP_DIV, 15, 1, 0);
    run4(OP_MOD, 3, 15, 0);
    run4(OP_MUL, 0, 9, 0);

    for (int i = 0; i < 40; i++)
      run4(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15)),
           1'($urandom));

    // Abort a multiply with reset while earlier results are still displayed.
    run4(OP_SUB, 3, 12, 0);
    @(negedge clk);
    bus4.start = 1'b1; bus4.op = OP_MUL; bus4.a = 4'd11; bus4.b = 4'd13;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midmul_busy", 32'(bus4.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midmul_reset_busy", 32'(bus4.busy), 32'd0);
    check("midmul_reset_done", 32'(bus4.done), 32'd0);
    check("midmul_reset_bcd", 32'(bus4.bcd_out), 32'd0);
    check("midmul_reset_neg", 32'(bus4.neg), 32'd0);
    check("midmul_reset_err", 32'(bus4.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus4.done || bus4.busy) done_n++;
    end
    check("midmul_no_done_after_abort", 32'(done_n), 32'd0);
    last4 = '0;
    run4(OP_ADD, 1, 1, 0);

    run8(OP_MUL, 255, 255);
    run8(OP_DIV, 200, 7);
    run8(OP_SUB, 10, 250);
    for (int i = 0; i < 10; i++)
      run8(3'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational calculator datapath.
- Accepts WIDTH-bit unsigned operands and a 3-bit opcode under a start/busy/done handshake.
- Runs iterative multiply and divide/modulo, then converts the magnitude to packed BCD internally with sequential double-dabble.
- Feeds the existing anode-scan / seven-segment display path with DIGITS BCD digits, plus sign and error flags.

Parameters:
- WIDTH, 4, operand width in bits (2..16); the result magnitude is 2*WIDTH bits.
- DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^(2*WIDTH)-1 (elaboration-time assertion).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- op  input  3  opcode
- busy  output  1  high from the cycle after an accepted start until DONE
- done  output  1  one-cycle pulse; outputs valid
- bcd_out  output  4*DIGITS  packed BCD of |result|, digit 0 in bits [3:0]
- neg  output  1  result negative (SUB only)
- err  output  1  divide/modulo by zero

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, bcd_out=0, neg=0, err=0; all internal counters and shift registers cleared. Reset mid-operation aborts with no done pulse.
- Opcodes:
  - 000 ADD: a+b
  - 001 SUB: |a-b|, neg=(a<b)
  - 010 MUL: a*b
  - 011 DIV: a/b quotient
  - 100 MOD: a%b
  - 101 AND, 110 OR, 111 XOR: zero-extended to 2*WIDTH
- Width rules: all results are 2*WIDTH bits, so no overflow is possible.
- FSM states: IDLE, EXEC, CONV, DONE.
- IDLE:
  - On an edge with start=1: latch a, b and op; go to EXEC; busy=1.
  - Otherwise hold. bcd_out, neg and err keep the last completed values.
- EXEC:
  - Single-cycle ops (ADD, SUB, logic): 1 edge, then CONV.
  - MUL: shift-add, WIDTH edges, then CONV.
  - DIV/MOD: restoring division, WIDTH edges, then CONV.
  - DIV/MOD with b=0: the first EXEC edge goes straight to DONE with err=1, bcd_out=0 and neg=0; CONV is skipped.
- CONV:
  - Double-dabble over 2*WIDTH edges: add-3 on every BCD nibble >=5, then shift left one bit.
  - The final shift edge loads bcd_out, neg and err=0, and enters DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start asserted during DONE is ignored; only IDLE accepts.
- start while busy: ignored, not queued. Operand or op changes after acceptance have no effect.
- Latency: with the accepting edge as edge 0, done is high in the cycle after edge L.
  - L = 1 + 2*WIDTH for single-cycle ops.
  - L = 3*WIDTH for MUL/DIV/MOD.
  - L = 1 for divide-by-zero.
  - WIDTH=4: ADD L=9, MUL L=12.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package seq_calc_pkg:
  - opcode localparams (OP_ADD..OP_XOR)
  - FSM state encoding
  - a digits-required helper function for the DIGITS assertion
- One natural sub-module: bin2bcd_seq. It is a parametrised (BIN_W=2*WIDTH, DIGITS) sequential double-dabble with a load/done interface and is instantiated for the CONV phase.
- Multiply and divide remain inline in EXEC, sharing one 2*WIDTH accumulator/shift register.

Test Plan:
- WIDTH=4, a=9, b=7, op=ADD, start at edge 0 -> done pulse after edge 9; bcd_out=16'h0016, neg=0, err=0; busy high for edges 1..9 cycles.
- a=3, b=12, op=SUB -> bcd_out=16'h0009, neg=1; then a=12, b=3, op=SUB -> bcd_out=16'h0009, neg=0.
- a=15, b=15, op=MUL -> done after edge 12, bcd_out=16'h0225; then a=13, b=4 with DIV -> 16'h0003, and with MOD -> 16'h0001.
- a=7, b=0, op=DIV -> done after edge 1, err=1, bcd_out=0; the next op ADD 1+1 -> err=0, bcd_out=16'h0002.
- A start pulse during busy and during DONE -> ignored; exactly one done per accepted start. Assert reset mid-MUL -> all outputs 0 immediately and no done pulse.
- WIDTH=8, DIGITS=5, a=255, b=255, op=MUL -> bcd_out=20'h65025 after edge 24.
